// File: rtl/tri_mat_inv_seq.sv
// Inverts an N x N triangular floating-point matrix by column-wise back-substitution,
// time-sharing a single divider, multiplier and adder.
module tri_mat_inv_seq #(
    parameter int N         = 3,
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    localparam int DWIDTH   = SIG_WIDTH + EXP_WIDTH + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            lower_in,
    input  logic [N-1:0][N-1:0][DWIDTH-1:0] mat_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N-1:0][N-1:0][DWIDTH-1:0] mat_out,
    output logic                            singular
);

    localparam int S  = SIG_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int T  = S + 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef logic [DWIDTH-1:0]   fp_t;
    typedef logic signed [E+2:0] exp_t;
    typedef logic [N-1:0][N-1:0][DWIDTH-1:0] mat_t;
    typedef enum logic [2:0] {IDLE, RECIP, ACC, SCALE, DONE} state_t;

    localparam exp_t BIAS   = exp_t'((1 << (E - 1)) - 1);
    localparam exp_t EMAX   = exp_t'((1 << E) - 1);
    localparam fp_t  FP_ONE = {2'b00, {(E-1){1'b1}}, {S{1'b0}}};

    function automatic exp_t ext_exp(input logic [E-1:0] e);
        return $signed({3'b000, e});
    endfunction

    // Round-to-nearest-even on a normalised significand; underflow flushes to zero.
    function automatic fp_t fp_round(input logic s, input exp_t e, input logic [S:0] m,
                                     input logic g, input logic st);
        logic [S+1:0] mr;
        exp_t         er;
        mr = {1'b0, m} + {{(S+1){1'b0}}, g & (st | m[0])};
        er = e;
        if (mr[S+1]) begin
            mr = mr >> 1;
            er = e + exp_t'(1);
        end
        if (er <= exp_t'(0)) return {s, {(DWIDTH-1){1'b0}}};
        if (er >= EMAX)      return {s, {E{1'b1}}, {S{1'b0}}};
        return {s, er[E-1:0], mr[S-1:0]};
    endfunction

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic           s;
        logic [2*S+1:0] p;
        exp_t           e;
        s = a[DWIDTH-1] ^ b[DWIDTH-1];
        if (a[DWIDTH-2:S] == '0 || b[DWIDTH-2:S] == '0) return {s, {(DWIDTH-1){1'b0}}};
        p = {{(S+1){1'b0}}, 1'b1, a[S-1:0]} * {{(S+1){1'b0}}, 1'b1, b[S-1:0]};
        e = ext_exp(a[DWIDTH-2:S]) + ext_exp(b[DWIDTH-2:S]) - BIAS;
        if (p[2*S+1]) e = e + exp_t'(1);
        else          p = p << 1;
        return fp_round(s, e, p[2*S+1:S+1], p[S], |p[S-1:0]);
    endfunction

    // Three extra bits (guard, round, sticky) below the significand are enough for RNE.
    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        fp_t          x, y;
        logic [T-1:0] mx, my, n;
        logic [2*T-1:0] sh;
        logic [T:0]   sum;
        logic [E-1:0] dexp;
        exp_t         e;
        int           d, lz;
        if (a[DWIDTH-2:0] >= b[DWIDTH-2:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        if (x[DWIDTH-2:S] == '0) return '0;
        if (y[DWIDTH-2:S] == '0) return x;
        mx   = {1'b1, x[S-1:0], 3'b000};
        dexp = x[DWIDTH-2:S] - y[DWIDTH-2:S];
        d    = int'(dexp);
        if (d > T) d = T;
        sh    = {1'b1, y[S-1:0], 3'b000, {T{1'b0}}} >> d;
        my    = sh[2*T-1:T];
        my[0] = my[0] | (|sh[T-1:0]);
        sum = (x[DWIDTH-1] != y[DWIDTH-1]) ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        if (sum == '0) return '0;
        e = ext_exp(x[DWIDTH-2:S]);
        if (sum[T]) begin
            n = {sum[T:2], sum[1] | sum[0]};
            e = e + exp_t'(1);
        end else begin
            lz = 0;
            for (int q = 0; q < T; q++) if (sum[q]) lz = T - 1 - q;
            n = sum[T-1:0] << lz;
            e = e - exp_t'(lz);
        end
        return fp_round(x[DWIDTH-1], e, n[T-1:3], n[2], |n[1:0]);
    endfunction

    function automatic fp_t fp_div(input fp_t a, input fp_t b);
        logic           s;
        logic [S:0]     ma, mb;
        logic [2*S+4:0] num, den, q, r;
        exp_t           e;
        s = a[DWIDTH-1] ^ b[DWIDTH-1];
        if (b[DWIDTH-2:S] == '0) return {s, {E{1'b1}}, {S{1'b0}}};
        if (a[DWIDTH-2:S] == '0) return {s, {(DWIDTH-1){1'b0}}};
        ma  = {1'b1, a[S-1:0]};
        mb  = {1'b1, b[S-1:0]};
        e   = ext_exp(a[DWIDTH-2:S]) - ext_exp(b[DWIDTH-2:S]) + BIAS;
        den = {{(S+4){1'b0}}, mb};
        // Pre-scale the dividend so the quotient always lands in [2^(S+3), 2^(S+4)).
        if (ma < mb) begin
            num = {ma, {(S+4){1'b0}}};
            e   = e - exp_t'(1);
        end else begin
            num = {1'b0, ma, {(S+3){1'b0}}};
        end
        q = num / den;
        r = num % den;
        return fp_round(s, e, q[S+3:3], q[2], (|q[1:0]) | (r != '0));
    endfunction

    state_t          state, state_nx;
    mat_t            u_r, x_r, u_in;
    fp_t [N-1:0]     d_r;
    fp_t             acc, mul_a, mul_b, mul_y, add_y, div_y;
    logic            lower_r, singular_r, diag_zero;
    logic [IW-1:0]   ri, ci, ki;

    always_comb begin
        u_in      = '0;
        diag_zero = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                u_in[r][c] = lower_in ? mat_in[c][r] : mat_in[r][c];
        for (int d = 0; d < N; d++)
            if (mat_in[d][d][DWIDTH-2:S] == '0) diag_zero = 1'b1;
    end

    // ACC feeds the multiplier from U and X; SCALE reuses it for acc * D[i].
    always_comb begin
        mul_a = acc;
        mul_b = d_r[ri];
        if (state == ACC) begin
            mul_a = u_r[ri][ki];
            mul_b = x_r[ki][ci];
        end
        mul_y = fp_mul(mul_a, mul_b);
        add_y = fp_add(acc, mul_y);
        div_y = fp_div(FP_ONE, u_r[ri][ri]);
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nx = diag_zero ? DONE : RECIP;
            RECIP:   if (ri == IW'(N - 1)) state_nx = ACC;
            ACC:     if (ki == ci) state_nx = SCALE;
            SCALE:   state_nx = (ri == '0 && ci == IW'(N - 1)) ? DONE : ACC;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            u_r        <= '0;
            x_r        <= '0;
            d_r        <= '0;
            acc        <= '0;
            lower_r    <= 1'b0;
            singular_r <= 1'b0;
            ri         <= '0;
            ci         <= '0;
            ki         <= '0;
        end else if (en) begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    u_r        <= u_in;
                    lower_r    <= lower_in;
                    singular_r <= diag_zero;
                    x_r        <= '0;
                    d_r        <= '0;
                    acc        <= '0;
                    ri         <= '0;
                    ci         <= IW'(1);
                    ki         <= IW'(1);
                end
                RECIP: begin
                    x_r[ri][ri] <= div_y;
                    d_r[ri]     <= div_y;
                    ri          <= (ri == IW'(N - 1)) ? '0 : ri + IW'(1);
                end
                ACC: begin
                    acc <= add_y;
                    ki  <= ki + IW'(1);
                end
                SCALE: begin
                    x_r[ri][ci] <= {~mul_y[DWIDTH-1], mul_y[DWIDTH-2:0]};
                    acc         <= '0;
                    // Next entry: move up the column, or start the next column at its sub-diagonal row.
                    if (ri == '0) begin
                        ci <= ci + IW'(1);
                        ri <= ci;
                        ki <= ci + IW'(1);
                    end else begin
                        ri <= ri - IW'(1);
                        ki <= ri;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mat_out = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (lower_r) mat_out[r][c] = (c <= r) ? x_r[c][r] : '0;
                else         mat_out[r][c] = (c >= r) ? x_r[r][c] : '0;
    end

    assign singular = singular_r;

endmodule

// File: tb/tb_tri_mat_inv_seq.sv
// Randomised self-checking bench for tri_mat_inv_seq; the reference model does each FP
// operation in real arithmetic and rounds the result to single precision.
module tb_tri_mat_inv_seq;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int C3 = 10;
    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, lower_in = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, singular;
    mat_t mat_in = '0, mat_out;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    tri_mat_inv_seq #(.N(N), .SIG_WIDTH(23), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .lower_in(lower_in), .mat_in(mat_in), .out_valid(out_valid), .out_ready(out_ready),
        .mat_out(mat_out), .singular(singular)
    );

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [31:0] b);
        real a;
        if (b[30:23] == 8'd0) return 0.0;
        a = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
        return b[31] ? -a : a;
    endfunction

    // Nearest-even rounding of a real to single precision (operands keep results in normal range).
    function automatic logic [31:0] from_real(input real v);
        real    a, m, f, rem;
        int     e;
        longint fi;
        logic   s;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m   = a * 8388608.0;
        f   = $floor(m);
        rem = m - f;
        fi  = longint'(f);
        if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
        if (fi == 64'd16777216) begin fi = 64'd8388608; e++; end
        return {s, 8'(e + 127), fi[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) * to_real(b));
    endfunction
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) + to_real(b));
    endfunction
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) / to_real(b));
    endfunction
    // +0 and -0 are the same value for a computed entry.
    function automatic logic [31:0] zc(input logic [31:0] a);
        return (a[30:0] == 31'd0) ? 32'h0 : a;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(124, 130));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    function automatic mat_t ident();
        mat_t m = '0;
        for (int i = 0; i < N; i++) m[i][i] = 32'h3F800000;
        return m;
    endfunction

    task automatic model(input mat_t m, input logic low, output mat_t res, output logic sing);
        logic [31:0] u [N][N];
        logic [31:0] x [N][N];
        logic [31:0] d [N];
        logic [31:0] acc;
        res  = '0;
        sing = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                u[r][c] = low ? m[c][r] : m[r][c];
                x[r][c] = 32'h0;
            end
        for (int i = 0; i < N; i++) if (u[i][i][30:23] == 8'd0) sing = 1'b1;
        if (sing) return;
        for (int r = 0; r < N; r++) begin
            d[r]    = fdiv(32'h3F800000, u[r][r]);
            x[r][r] = d[r];
        end
        for (int j = 1; j < N; j++)
            for (int i = j - 1; i >= 0; i--) begin
                acc = 32'h0;
                for (int k = i + 1; k <= j; k++) acc = fadd(acc, fmul(u[i][k], x[k][j]));
                x[i][j] = fmul(acc, d[i]) ^ 32'h80000000;
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                res[r][c] = low ? ((c <= r) ? x[c][r] : 32'h0) : ((c >= r) ? x[r][c] : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then count edges until out_valid (bounded).
    task automatic send(input mat_t m, input logic low, output int cyc);
        mat_in   = m;
        lower_in = low;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL reset_singular got %b exp 0", singular); end
        checks++; if (mat_out !== '0) begin errors++; $display("FAIL reset_mat_out got %h exp 0", mat_out); end
    endtask

    task automatic test_en_idle();
        en = 1'b0; mat_in = ident(); in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_low_no_accept in_ready got %b exp 1", in_ready); end
        en = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_low_no_accept out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_identity();
        int cyc;
        logic [31:0] e;
        send(ident(), 1'b0, cyc);
        checks++; if (cyc !== C3) begin errors++; $display("FAIL ident_latency got %0d exp %0d", cyc, C3); end
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL ident_singular got %b exp 0", singular); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                e = (r == c) ? 32'h3F800000 : 32'h0;
                checks++;
                if (zc(mat_out[r][c]) !== e) begin
                    errors++; $display("FAIL ident_entry[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], e);
                end
            end
        consume();
    endtask

    task automatic test_known();
        int cyc;
        mat_t u = '0, ut;
        logic [31:0] xk [N][N];
        xk = '{'{32'h3F000000, 32'hBE000000, 32'h3D000000},
               '{32'h0,        32'h3E800000, 32'hBD800000},
               '{32'h0,        32'h0,        32'h3E000000}};
        u[0][0] = 32'h40000000; u[0][1] = 32'h3F800000;
        u[1][1] = 32'h40800000; u[1][2] = 32'h40000000;
        u[2][2] = 32'h41000000;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) ut[r][c] = u[c][r];
        send(u, 1'b0, cyc);
        checks++; if (cyc !== C3) begin errors++; $display("FAIL known_upper_latency got %0d exp %0d", cyc, C3); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== xk[r][c]) begin
                    errors++; $display("FAIL known_upper[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], xk[r][c]);
                end
            end
        consume();
        send(ut, 1'b1, cyc);
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL known_lower_singular got %b exp 0", singular); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== xk[c][r]) begin
                    errors++; $display("FAIL known_lower[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], xk[c][r]);
                end
            end
        consume();
    endtask

    task automatic test_singular();
        int cyc;
        mat_t u = '0;
        u[0][0] = 32'h40000000; u[0][1] = 32'h3F800000;
        u[1][2] = 32'h40000000; u[2][2] = 32'h41000000;
        send(u, 1'b0, cyc);
        // Result is visible in the cycle right after the accept edge.
        checks++; if (cyc !== 0) begin errors++; $display("FAIL sing_latency got %0d exp 0", cyc); end
        checks++; if (singular !== 1'b1) begin errors++; $display("FAIL sing_flag got %b exp 1", singular); end
        checks++; if (mat_out !== '0) begin errors++; $display("FAIL sing_mat_out got %h exp 0", mat_out); end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        mat_t m, em, snap;
        logic es;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m[r][c] = rand_fp();
        model(m, 1'b0, em, es);
        send(m, 1'b0, cyc);
        snap = mat_out;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid t%0d got %b exp 1", t, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t%0d got %b exp 0", t, in_ready); end
            checks++; if (mat_out !== snap) begin errors++; $display("FAIL bp_mat_stable t%0d got %h exp %h", t, mat_out, snap); end
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== zc(em[r][c])) begin
                    errors++; $display("FAIL bp_entry[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], em[r][c]);
                end
            end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc;
        mat_t a, b, em;
        logic es;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin a[r][c] = rand_fp(); b[r][c] = rand_fp(); end
        send(a, 1'b0, cyc);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_done got %b exp 0", in_ready); end
        // Offer the next matrix during the consuming edge; it must not be taken there.
        mat_in = b; lower_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_after got %b exp 0", out_valid); end
        model(b, 1'b1, em, es);
        send(b, 1'b1, cyc);
        checks++; if (cyc !== C3) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc, C3); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== zc(em[r][c])) begin
                    errors++; $display("FAIL b2b_entry[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], em[r][c]);
                end
            end
        consume();
    endtask

    task automatic test_stall();
        int cyc;
        mat_t m, em;
        logic es;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m[r][c] = rand_fp();
        model(m, 1'b0, em, es);
        mat_in = m; lower_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        // Three enabled edges finish the reciprocals, then three disabled edges in ACC.
        while (!out_valid && cyc < 200) begin
            en = (cyc >= 3 && cyc < 6) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        en = 1'b1;
        checks++; if (cyc !== C3 + 3) begin errors++; $display("FAIL stall_latency got %0d exp %0d", cyc, C3 + 3); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== zc(em[r][c])) begin
                    errors++; $display("FAIL stall_entry[%0d][%0d] got %h exp %h", r, c, mat_out[r][c], em[r][c]);
                end
            end
        consume();
    endtask

    task automatic test_reset_mid();
        int cyc;
        mat_in = ident(); lower_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0; en = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
        checks++; if (mat_out !== '0) begin errors++; $display("FAIL rstmid_mat_out got %h exp 0", mat_out); end
        send(ident(), 1'b0, cyc);
        checks++; if (cyc !== C3) begin errors++; $display("FAIL rstmid_latency got %0d exp %0d", cyc, C3); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (zc(mat_out[r][c]) !== ((r == c) ? 32'h3F800000 : 32'h0)) begin
                    errors++; $display("FAIL rstmid_entry[%0d][%0d] got %h", r, c, mat_out[r][c]);
                end
            end
        consume();
    endtask

    task automatic test_random();
        int cyc, exp_lat, z;
        mat_t m, em;
        logic low, es;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m[r][c] = rand_fp();
            if ($urandom_range(0, 4) == 0) begin
                z = $urandom_range(0, N - 1);
                m[z][z][30:23] = 8'd0;
            end
            low = 1'($urandom_range(0, 1));
            model(m, low, em, es);
            exp_lat = es ? 0 : C3;
            send(m, low, cyc);
            checks++; if (cyc !== exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", it, cyc, exp_lat); end
            checks++; if (singular !== es) begin errors++; $display("FAIL rand%0d_singular got %b exp %b", it, singular, es); end
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    checks++;
                    if (zc(mat_out[r][c]) !== zc(em[r][c])) begin
                        errors++; $display("FAIL rand%0d_entry[%0d][%0d] got %h exp %h", it, r, c, mat_out[r][c], em[r][c]);
                    end
                end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_en_idle();
        test_identity();
        test_known();
        test_singular();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_mat_inv_seq.md
TRI_MAT_INV_SEQ -- requirements
Module: tri_mat_inv_seq

Interface
REQ-001 SHALL have parameter N, 3, matrix dimension; legal range 2..8.
REQ-002 SHALL have parameter SIG_WIDTH, 23, FP significand bits.
REQ-003 SHALL have parameter EXP_WIDTH, 8, FP exponent bits; DWIDTH = SIG_WIDTH+EXP_WIDTH+1 (derived).
REQ-004 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  in  1  clock enable; when low, all state and outputs hold.
REQ-007 SHALL have port in_valid  in  1  input matrix valid.
REQ-008 SHALL have port in_ready  out  1  block can accept a matrix.
REQ-009 SHALL have port lower_in  in  1  0: mat_in upper triangular; 1: lower triangular; sampled on accept.
REQ-010 SHALL have port mat_in  in  N x N x DWIDTH  input matrix [row][col]; entries outside the triangle are ignored.
REQ-011 SHALL have port out_valid  out  1  mat_out holds a result.
REQ-012 SHALL have port out_ready  in  1  consumer takes the result.
REQ-013 SHALL have port mat_out  out  N x N x DWIDTH  inverse matrix [row][col].
REQ-014 SHALL have port singular  out  1  result invalid because a diagonal entry was zero or denormal; qualified by out_valid.

Function
REQ-015 SHALL use FSM states IDLE, RECIP, ACC, SCALE, DONE; every transition happens only on an edge with en=1.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept occurs when in_valid && in_ready && en.
REQ-017 On accept, SHALL register mat_in and lower_in; when lower_in=1, SHALL use the transpose of mat_in as the internal matrix U.
REQ-018 On accept, if any U[i][i] has a zero exponent field, SHALL go to DONE with singular=1 and mat_out all zero, so out_valid is high 1 cycle after accept.
REQ-019 Otherwise SHALL go to RECIP: N cycles, cycle r writes D[r] = X[r][r] = 1/U[r][r].
REQ-020 SHALL then compute off-diagonal entries in order: column j ascending 1..N-1, and within each column row i descending j-1..0.
REQ-021 Per (i,j), SHALL clear acc, then spend j-i ACC cycles (k = i+1..j) on acc <= acc + U[i][k]*X[k][j].
REQ-022 Per (i,j), after the ACC cycles SHALL spend one SCALE cycle on X[i][j] <= -(acc*D[i]); negation is a sign-bit flip.
REQ-023 SHALL use one divider, one multiplier and one adder, each combinational single-cycle DesignWare FP with rnd=0 (round to nearest even) and ieee_compliance=0.
REQ-024 Latency: with en held high, out_valid SHALL rise C cycles after the accept edge, where C = N + sum over d=1..N-1 of (N-d)(d+1).
  - N=3: C=10.
  - N=4: C=20.
REQ-025 In DONE, SHALL assert out_valid and hold mat_out and singular stable until an edge with out_ready && en, then return to IDLE.
REQ-026 SHALL not accept a new input in the same cycle the result is consumed; in_ready rises the following cycle.
REQ-027 SHALL present X on mat_out when lower=0 and X transposed when lower=1.
REQ-028 SHALL drive the opposite strict triangle of mat_out to 0 at all times.
REQ-029 When en=0 mid-computation, SHALL freeze; latency counts only cycles with en=1.

Reset
REQ-030 While rst_n=0 at an edge, SHALL enter IDLE and clear acc, D, X and the captured matrix to 0.
REQ-031 While rst_n=0 at an edge, SHALL set out_valid=0, singular=0, mat_out all 0, and in_ready=1 after that edge.
REQ-032 A reset during RECIP/ACC/SCALE/DONE SHALL abort the operation with no output, regardless of en.

Verification
REQ-033 N=3 identity, lower_in=0 -> out_valid 10 cycles after accept; mat_out = identity (3F800000 diagonal, 0 elsewhere); singular=0.
REQ-034 N=3, U=[[2,1,0],[0,4,2],[0,0,8]] -> mat_out rows:
  - row 0: [3F000000, BE000000, 3D000000]
  - row 1: [0, 3E800000, BD800000]
  - row 2: [0, 0, 3E000000]
REQ-035 Transpose of REQ-034's U with lower_in=1 -> mat_out equals the transpose of REQ-034's result; upper strict triangle 0.
REQ-036 N=3, U[1][1]=0 -> out_valid one cycle after accept; singular=1; mat_out all 0.
REQ-037 Backpressure and stall:
  - out_ready low for 5 cycles -> mat_out and out_valid stable, in_ready=0.
  - en low for 3 cycles mid-ACC -> out_valid rises at 13 cycles instead of 10.
REQ-038 rst_n low for 1 cycle during ACC -> next cycle IDLE, in_ready=1, out_valid=0; a subsequent identity input gives a correct result.
